// File: rtl/load_store_unit_if.sv
// Core-side and memory-side bundles of the load/store unit.
// Handshake: a request transfers on the rising edge where req_valid && req_ready; the
// core holds all req_* fields stable until then. resp_valid is a one-cycle pulse with no
// back-pressure. mem_req stays high, with fields stable, until mem_ack or the unit times out.
interface lsu_core_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface lsu_mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/load_store_unit.sv
// Data-memory initiator: checks a core load/store, issues a word-addressed memory
// request with byte enables, and returns extended load data or an error.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic       sysclk,
  input  logic       rst_n,
  lsu_core_if.slave  core,
  lsu_mem_if.master  mem,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic        f3_legal, aligned, req_ok;
  logic [3:0]  req_be;
  logic [31:0] req_wdata_lane;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Decode of the incoming request; width is funct3[1:0], signedness funct3[2].
  always_comb begin
    logic [2:0] f3;
    logic [1:0] a;
    f3 = core.req_funct3;
    a  = core.req_addr[1:0];
    if (core.req_we) f3_legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    else             f3_legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                                (f3 == 3'b100) || (f3 == 3'b101);
    aligned = !((f3[1:0] == 2'b01) && a[0]) && !((f3[1:0] == 2'b10) && (a != 2'b00));
    req_ok  = f3_legal && aligned;
    case (f3[1:0])
      2'b00:   req_be = 4'b0001 << a;
      2'b01:   req_be = a[1] ? 4'b1100 : 4'b0011;
      default: req_be = 4'b1111;
    endcase
    if (!core.req_we) req_wdata_lane = 32'h0;
    else begin
      case (f3[1:0])
        2'b00:   req_wdata_lane = {4{core.req_wdata[7:0]}};
        2'b01:   req_wdata_lane = {2{core.req_wdata[15:0]}};
        default: req_wdata_lane = core.req_wdata;
      endcase
    end
  end

  always_comb begin
    case (addr_lo_q)
      2'd0:    ld_byte = mem.mem_rdata[7:0];
      2'd1:    ld_byte = mem.mem_rdata[15:8];
      2'd2:    ld_byte = mem.mem_rdata[23:16];
      default: ld_byte = mem.mem_rdata[31:24];
    endcase
    ld_half = addr_lo_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = mem.mem_rdata;
    endcase
    if (we_q) ld_data = 32'h0;
  end

  // State register
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      addr_lo_q    <= 2'b00;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_be_q     <= 4'h0;
      mem_wdata_q  <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      addr_lo_q    <= addr_lo_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Next-state logic; ack is checked before the timeout so it wins a tie.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (core.req_valid) state_d = req_ok ? S_WAIT : S_RESP;
      S_WAIT: if (mem.mem_ack || (cnt_q == CNT_LAST)) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    cnt_d        = (state_q == S_WAIT) ? cnt_q + 1'b1 : '0;
    we_d         = we_q;
    funct3_d     = funct3_q;
    addr_lo_d    = addr_lo_q;
    mem_req_d    = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (core.req_valid) begin
          we_d      = core.req_we;
          funct3_d  = core.req_funct3;
          addr_lo_d = core.req_addr[1:0];
          if (req_ok) begin
            mem_req_d   = 1'b1;
            mem_we_d    = core.req_we;
            mem_addr_d  = {core.req_addr[31:2], 2'b00};
            mem_be_d    = req_be;
            mem_wdata_d = req_wdata_lane;
          end else begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
          end
        end
      end
      S_WAIT: begin
        if (mem.mem_ack) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = ld_data;
        end else if (cnt_q == CNT_LAST) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = 32'h0;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign core.req_ready  = (state_q == S_IDLE);
  assign core.resp_valid = resp_valid_q;
  assign core.resp_err   = resp_err_q;
  assign core.resp_rdata = resp_rdata_q;
  assign mem.mem_req     = mem_req_q;
  assign mem.mem_we      = mem_we_q;
  assign mem.mem_addr    = mem_addr_q;
  assign mem.mem_be      = mem_be_q;
  assign mem.mem_wdata   = mem_wdata_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a driver issues requests and plays the memory,
// expected responses go into a queue that a negedge monitor pops and compares.
module tb_load_store_unit;

  logic       sysclk;
  logic       rst_n;
  logic [1:0] dbg_state;

  lsu_core_if cif();
  lsu_mem_if  mif();

  load_store_unit #(.TIMEOUT(16)) dut (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .core      (cif.slave),
    .mem       (mif.master),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [32:0] exp_q[$];
  logic [32:0] exp_item;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: {err, rdata} per response pulse
  always @(negedge sysclk) begin
    if (rst_n === 1'b1 && cif.resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL resp_unexpected: got err=%0b rdata=0x%0h, expected no response",
                 cif.resp_err, cif.resp_rdata);
      end else begin
        exp_item = exp_q.pop_front();
        check("resp", {cif.resp_err, cif.resp_rdata}, exp_item);
      end
    end
  end

  task automatic wait_ready(input string name);
    int w = 0;
    @(negedge sysclk);
    while (cif.req_ready !== 1'b1 && w < 20) begin
      @(negedge sysclk);
      w++;
    end
    check({name, "_ready_wait"}, {32'h0, cif.req_ready}, 33'h1);
  endtask

  // Issue one request and act as the memory; ack_cycle counts mem_req cycles (0 = never).
  task automatic do_txn(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rword, input int ack_cycle,
                        input logic exp_err, input logic [31:0] exp_rdata,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input int exp_nreq, input int exp_lat);
    int c = 0;
    int nreq = 0;
    int lat = -1;
    exp_q.push_back({exp_err, exp_rdata});
    wait_ready(name);
    cif.req_valid  = 1'b1;
    cif.req_we     = we;
    cif.req_funct3 = f3;
    cif.req_addr   = addr;
    cif.req_wdata  = wdata;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(negedge sysclk);
      c++;
      mif.mem_ack = 1'b0;
      if (c == 1) begin
        cif.req_valid = 1'b0;
        check({name, "_busy"}, {32'h0, cif.req_ready}, 33'h0);
        check({name, "_state"}, {31'h0, dbg_state}, (exp_nreq > 0) ? 33'd1 : 33'd2);
      end
      if (mif.mem_req === 1'b1) begin
        nreq++;
        if (nreq == 1) begin
          check({name, "_addr"},  {1'b0, mif.mem_addr}, {1'b0, addr[31:2], 2'b00});
          check({name, "_be"},    {29'h0, mif.mem_be}, {29'h0, exp_be});
          check({name, "_we"},    {32'h0, mif.mem_we}, {32'h0, we});
          check({name, "_wdata"}, {1'b0, mif.mem_wdata}, {1'b0, exp_wdata});
        end
        if (nreq == ack_cycle) begin
          mif.mem_ack   = 1'b1;
          mif.mem_rdata = rword;
        end
      end
      if (cif.resp_valid === 1'b1) lat = c;
    end
    mif.mem_ack = 1'b0;
    check({name, "_nreq"},    33'(nreq), 33'(exp_nreq));
    check({name, "_latency"}, 33'(lat),  33'(exp_lat));
  endtask

  initial begin
    rst_n          = 1'b0;
    cif.req_valid  = 1'b0;
    cif.req_we     = 1'b0;
    cif.req_funct3 = 3'b000;
    cif.req_addr   = 32'h0;
    cif.req_wdata  = 32'h0;
    mif.mem_ack    = 1'b0;
    mif.mem_rdata  = 32'h0;
    repeat (2) @(negedge sysclk);
    check("rst_ready",      {32'h0, cif.req_ready}, 33'h1);
    check("rst_state",      {31'h0, dbg_state}, 33'h0);
    check("rst_mem_req",    {32'h0, mif.mem_req}, 33'h0);
    check("rst_mem_we",     {32'h0, mif.mem_we}, 33'h0);
    check("rst_resp_valid", {32'h0, cif.resp_valid}, 33'h0);
    check("rst_resp",       {cif.resp_err, cif.resp_rdata}, 33'h0);
    check("rst_mem_addr",   {1'b0, mif.mem_addr}, 33'h0);
    check("rst_mem_be",     {29'h0, mif.mem_be}, 33'h0);
    check("rst_mem_wdata",  {1'b0, mif.mem_wdata}, 33'h0);
    rst_n = 1'b1;

    //      name    we  f3      addr    wdata         rword         ack err rdata         be       wdata         nreq lat
    do_txn("sw",    1, 3'b010, 32'h44, 32'hDEADBEEF, 32'hFFFFFFFF, 3, 0, 32'h0,        4'b1111, 32'hDEADBEEF, 3,  4);
    do_txn("lb",    0, 3'b000, 32'h03, 32'h0,        32'h80C0FFEE, 1, 0, 32'hFFFFFF80, 4'b1000, 32'h0,        1,  2);
    do_txn("lbu",   0, 3'b100, 32'h03, 32'h0,        32'h80C0FFEE, 1, 0, 32'h00000080, 4'b1000, 32'h0,        1,  2);
    do_txn("sh",    1, 3'b001, 32'h06, 32'h1234ABCD, 32'hFFFFFFFF, 2, 0, 32'h0,        4'b1100, 32'hABCDABCD, 2,  3);
    do_txn("lh",    0, 3'b001, 32'h02, 32'h0,        32'hA5A50000, 1, 0, 32'hFFFFA5A5, 4'b1100, 32'h0,        1,  2);
    do_txn("lhu",   0, 3'b101, 32'h02, 32'h0,        32'hA5A50000, 1, 0, 32'h0000A5A5, 4'b1100, 32'h0,        1,  2);
    do_txn("sb",    1, 3'b000, 32'h101,32'h000000AB, 32'hFFFFFFFF, 1, 0, 32'h0,        4'b0010, 32'hABABABAB, 1,  2);
    do_txn("lh_lo", 0, 3'b001, 32'h10, 32'h0,        32'h12348001, 1, 0, 32'hFFFF8001, 4'b0011, 32'h0,        1,  2);
    do_txn("lw_mis",0, 3'b010, 32'h41, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        0,  1);
    do_txn("f3_011",0, 3'b011, 32'h40, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        0,  1);
    do_txn("st_100",1, 3'b100, 32'h40, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        0,  1);
    do_txn("sh_mis",1, 3'b001, 32'h05, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        0,  1);
    do_txn("lw_to", 0, 3'b010, 32'h48, 32'h0,        32'h0,        0, 1, 32'h0,        4'b1111, 32'h0,        16, 17);
    do_txn("lw_ack16",0,3'b010,32'h4C, 32'h0,        32'h11223344, 16,0, 32'h11223344, 4'b1111, 32'h0,        16, 17);

    // Acknowledge while idle must not produce anything
    @(negedge sysclk);
    mif.mem_ack = 1'b1;
    repeat (2) @(negedge sysclk);
    mif.mem_ack = 1'b0;
    check("idle_ack_mem_req", {32'h0, mif.mem_req}, 33'h0);
    check("idle_ack_state",   {31'h0, dbg_state}, 33'h0);

    // Reset in the middle of a WAIT drops the transaction
    wait_ready("rst_mid");
    cif.req_valid  = 1'b1;
    cif.req_we     = 1'b0;
    cif.req_funct3 = 3'b010;
    cif.req_addr   = 32'h80;
    @(negedge sysclk);
    cif.req_valid = 1'b0;
    check("rst_mid_in_wait", {32'h0, mif.mem_req}, 33'h1);
    repeat (2) @(negedge sysclk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_mem_req",    {32'h0, mif.mem_req}, 33'h0);
    check("rst_mid_resp_valid", {32'h0, cif.resp_valid}, 33'h0);
    check("rst_mid_ready",      {32'h0, cif.req_ready}, 33'h1);
    repeat (2) @(negedge sysclk);
    rst_n = 1'b1;
    do_txn("lw_after_rst", 0, 3'b010, 32'h80, 32'h0, 32'hCAFEF00D, 2, 0, 32'hCAFEF00D,
           4'b1111, 32'h0, 2, 3);

    repeat (3) @(negedge sysclk);
    check("queue_empty", 33'(exp_q.size()), 33'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory port in the RISC-V simple datapath. It accepts one load/store per transaction from the execute stage, then checks alignment and encoding. It drives a word-addressed memory request with byte enables and waits for the memory's acknowledge. It returns sign- or zero-extended load data, or an error, to the core. A bounded wait converts a missing acknowledge into an error response.

## Interface
- TIMEOUT, 16, max cycles in WAIT without mem_ack before an error response (≥2)
- sysclk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  core request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low bits used for SB/SH)
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, illegal funct3 or timeout; qualified by resp_valid
- mem_req  out  1  memory request, held until ack or timeout
- mem_we  out  1  memory write strobe, qualified by mem_req
- mem_addr  out  32  {req_addr[31:2], 2'b00}
- mem_be  out  4  byte-lane enables
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  read word, valid when mem_ack=1
- mem_ack  in  1  one-cycle completion pulse from memory

## Operation
- States: IDLE, WAIT, RESP. Reset → IDLE.
- IDLE: req_ready=1. On req_valid, latch all request fields.
  - Legal and aligned request → WAIT.
  - Illegal or misaligned request → RESP with err=1. No memory access is made.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value → illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]≠00.
- mem_be is driven for loads and stores alike:
  - byte: 4'b0001<<addr[1:0]
  - half: addr[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
- mem_wdata:
  - SB: {4{wdata[7:0]}}
  - SH: {2{wdata[15:0]}}
  - SW: wdata
  - Loads: 0
- WAIT: mem_req=1. A wait counter starts at 0 and increments each cycle.
  - mem_ack=1 → capture the result and go to RESP.
  - Counter reaches TIMEOUT-1 without ack → RESP with err=1 and rdata=0.
  - Ack and timeout in the same cycle: ack wins (no error).
- Load extraction: select the byte or half by addr[1:0] / addr[1] from mem_rdata. Sign-extend for LB/LH, zero-extend for LBU/LHU.
- RESP: resp_valid=1 for exactly one cycle, then → IDLE. resp_rdata and resp_err are held until the next response.
- mem_ack outside WAIT is ignored.
- All outputs are registered except req_ready, which is decoded from state.

## Timing
- Reset values:
  - State IDLE, req_ready=1.
  - mem_req, mem_we, resp_valid, resp_err = 0.
  - mem_addr, mem_be, mem_wdata, resp_rdata = 0.
- Normal transaction:
  - Request accepted at edge 0.
  - mem_req high from cycle 1. mem_we/addr/be/wdata are stable while mem_req=1.
  - Ack sampled at edge k → mem_req low from cycle k+1, and resp_valid high in cycle k+1.
  - Minimum latency, accept to resp_valid: 2 cycles (ack in cycle 1).
- Error path (illegal/misaligned): resp_valid in cycle 1. mem_req never asserts.
- Timeout: mem_req is held for exactly TIMEOUT cycles. resp_valid rises in the following cycle.
- Back-to-back: the next request is accepted in the cycle after resp_valid (IDLE). Throughput is at most one transaction per 3 cycles.
- req_valid while not in IDLE is not accepted. The core must hold the request until req_ready=1.
- Reset mid-transaction: mem_req and resp_valid drop immediately (asynchronous). The transaction is dropped without a response.

## Test plan
- SW addr 0x44, wdata 0xDEADBEEF, ack in cycle 3 → mem_addr=0x44, be=1111, mem_we=1, mem_req high for cycles 1-3, resp_valid in cycle 4, err=0, rdata=0.
- LB addr 0x03, mem_rdata 0x80C0FFEE → be=1000, rdata=0xFFFFFF80. Repeat with LBU → rdata=0x00000080.
- SH addr 0x06, wdata 0x1234ABCD → mem_wdata=0xABCDABCD, be=1100. LH addr 0x02 on rdata 0xA5A5_0000 → 0xFFFFA5A5.
- LW addr 0x41, and separately funct3=011 → resp_valid in cycle 1 with err=1 and no mem_req pulse.
- LW with ack never asserted, TIMEOUT=16 → mem_req high for exactly 16 cycles, err=1, rdata=0. Then an ack on the last WAIT cycle → err=0.
- Assert rst_n=0 during WAIT → mem_req=0 immediately, no resp_valid. After release, req_ready=1 and a fresh LW completes normally.
